// File: rtl/jts18_pri_pkg.sv
// Shared types for the System 18 layer-priority gate: the rank type used by
// every plane and the VDP, and the states of the next-permutation walker.
package jts18_pri_pkg;

   localparam int RANK_W     = 3;
   localparam int MAX_LAYERS = 8;

   typedef logic [RANK_W-1:0] rank_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FIND_I  = 3'd1,
      ST_FIND_J  = 3'd2,
      ST_SWAP    = 3'd3,
      ST_REVERSE = 3'd4,
      ST_COMMIT  = 3'd5
   } perm_state_t;

   // Identity order for the widest build; callers keep the low LAYERS entries.
   function automatic logic [MAX_LAYERS*RANK_W-1:0] identity_order();
      logic [MAX_LAYERS*RANK_W-1:0] r;
      r = '0;
      for (int k = 0; k < MAX_LAYERS; k++) r[k*RANK_W +: RANK_W] = RANK_W'(k);
      return r;
   endfunction

endpackage

// File: rtl/jts18_pri_perm.sv
// Lexicographic next-permutation walker over the working order ord[].
// One request advances ord[] by one permutation, one index or swap per cycle;
// done pulses in COMMIT so the owner can copy ord[] in one go.
module jts18_pri_perm
   import jts18_pri_pkg::*;
#(
   parameter int LAYERS = 5,
   parameter int LW     = $clog2(LAYERS)
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               req,
   output logic               busy,
   output logic               done,
   output rank_t [LAYERS-1:0] ord,
   output logic [15:0]        perm_cnt,
   output perm_state_t        state
);

   localparam rank_t [LAYERS-1:0] IDENT = (RANK_W*LAYERS)'(identity_order());

   perm_state_t   state_nx;
   logic [LW-1:0] i, j, lo, hi;

   // State register; clr returns the walker to IDLE even mid-permutation.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, whatever order the statements run in.
      if (rst || clr) state <= ST_IDLE;
      else            state <= state_nx;
   end

   // Next state and handshake outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_nx = state;
      busy     = (state != ST_IDLE);
      done     = (state == ST_COMMIT);
      case (state)
         ST_IDLE:    if (req) state_nx = ST_FIND_I;
         ST_FIND_I: begin
            if (ord[i] < ord[i + 1'b1]) state_nx = ST_FIND_J;
            else if (i == '0)           state_nx = ST_COMMIT;
         end
         ST_FIND_J:  if (ord[j] > ord[i]) state_nx = ST_SWAP;
         ST_SWAP:    state_nx = ST_REVERSE;
         ST_REVERSE: if (lo >= hi) state_nx = ST_COMMIT;
         ST_COMMIT:  state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Working order, scan indices and permutation counter.
   always_ff @(posedge clk) begin
      // NOTE: ord[] is reset because identity is the defined starting order;
      // the scan indices are reset only to keep simulation free of X.
      if (rst || clr) begin
         ord      <= IDENT;
         perm_cnt <= '0;
         i        <= '0;
         j        <= '0;
         lo       <= '0;
         hi       <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req) i <= LW'(LAYERS-2);
            ST_FIND_I: begin
               if (ord[i] < ord[i + 1'b1]) begin
                  j <= LW'(LAYERS-1);
               end else if (i == '0) begin
                  // Last permutation reached: wrap order and count together.
                  ord      <= IDENT;
                  perm_cnt <= '0;
               end else begin
                  i <= i - 1'b1;
               end
            end
            ST_FIND_J: if (!(ord[j] > ord[i])) j <= j - 1'b1;
            ST_SWAP: begin
               ord[i] <= ord[j];
               ord[j] <= ord[i];
               lo     <= i + 1'b1;
               hi     <= LW'(LAYERS-1);
            end
            ST_REVERSE: begin
               if (lo < hi) begin
                  ord[lo] <= ord[hi];
                  ord[hi] <= ord[lo];
                  lo      <= lo + 1'b1;
                  hi      <= hi - 1'b1;
               end else begin
                  perm_cnt <= perm_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/jts18_vdp_pri_seq.sv
// Layer-priority gate for the System 18 VDP/tilemap/object mixer.
// Two-stage pipeline: stage 1 registers the pixel and each plane's rank, stage 2
// picks the highest-ranked opaque plane and decides whether the VDP pixel wins.
// Build option: define JTS18_PRI_SEQ_EN to add the permutation test sequencer
// (frame counter, run/step buttons, next-permutation FSM, debug status). Without
// it the order is fixed at identity and st_show reads zero.
module jts18_vdp_pri_seq
   import jts18_pri_pkg::*;
#(
   parameter int LAYERS = 5,
   parameter int LW     = $clog2(LAYERS),
   parameter int VBLS   = 180
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              LVBL,
   input  logic [1:0]        buttons,
   input  logic [7:0]        debug_bus,
   input  logic [LAYERS-1:0] opaque,
   input  logic              vdp_opaque,
   input  logic [2:0]        vdp_prio,
   output logic              vdp_sel,
   output logic [LW-1:0]     lyr_sel,
   output logic              lyr_vld,
   output logic [7:0]        st_show
);

   localparam rank_t [LAYERS-1:0] IDENT = (RANK_W*LAYERS)'(identity_order());

   rank_t [LAYERS-1:0] act_ord;

   logic [LAYERS-1:0]  s1_opaque;
   logic               s1_vdp_opaque;
   rank_t              s1_vdp_prio;
   rank_t [LAYERS-1:0] s1_rank;
   logic [LW-1:0]      win_idx;
   rank_t              win_rank;
   logic               win_vld;

   // Stage 1: register the pixel and map every plane to its active rank.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_opaque     <= '0;
         s1_vdp_opaque <= 1'b0;
         s1_vdp_prio   <= '0;
         s1_rank       <= '0;
      end else begin
         s1_opaque     <= opaque;
         s1_vdp_opaque <= vdp_opaque;
         s1_vdp_prio   <= vdp_prio;
         s1_rank       <= act_ord;
      end
   end

   // Highest-ranked opaque plane; ranks are a permutation so there are no ties.
   always_comb begin
      win_idx  = '0;
      win_rank = '0;
      win_vld  = 1'b0;
      for (int p = 0; p < LAYERS; p++) begin
         if (s1_opaque[p] && (!win_vld || s1_rank[p] > win_rank)) begin
            win_vld  = 1'b1;
            win_rank = s1_rank[p];
            win_idx  = LW'(p);
         end
      end
   end

   // Stage 2: the VDP needs a strictly higher rank, so a tie goes to the plane.
   always_ff @(posedge clk) begin
      if (rst) begin
         vdp_sel <= 1'b0;
         lyr_sel <= '0;
         lyr_vld <= 1'b0;
      end else begin
         vdp_sel <= s1_vdp_opaque && (!win_vld || s1_vdp_prio > win_rank);
         lyr_sel <= win_idx;
         lyr_vld <= win_vld;
      end
   end

`ifdef JTS18_PRI_SEQ_EN

   logic [1:0]  lvbl_sr;      // [0] current, [1] previous
   logic [1:0]  btn_q;
   logic [7:0]  frame_cnt;
   logic        run;
   logic        pending;
   logic        soft_clr;
   logic        vbl_edge;
   logic        frame_wrap;
   logic [1:0]  btn_fall;
   logic        adv_req;
   logic        perm_req;
   logic        perm_busy;
   logic        perm_done;
   logic [15:0] perm_cnt;
   perm_state_t perm_state;
   logic [2:0]  lyr_sel3;
   rank_t [LAYERS-1:0] work_ord;
   logic        unused_bits;

   // Both buttons low is an operator-driven clear; it acts on the raw input so
   // it lands on the very next edge and overrides any request in flight.
   assign soft_clr   = (buttons == 2'b00);
   assign vbl_edge   = lvbl_sr[0] & ~lvbl_sr[1];
   assign frame_wrap = vbl_edge && (frame_cnt == 8'(VBLS-1));
   assign btn_fall   = btn_q & ~buttons;
   assign adv_req    = btn_fall[0] | (frame_wrap & run);
   assign perm_req   = !perm_busy && (adv_req || pending);
   assign lyr_sel3   = 3'(lyr_sel);
   assign unused_bits = ^{perm_cnt[15:8], debug_bus[6:1]};

   // Input sampling for edge detection; idle levels avoid a spurious edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvbl_sr <= 2'b11;
         btn_q   <= 2'b11;
      end else begin
         lvbl_sr <= {lvbl_sr[0], LVBL};
         btn_q   <= buttons;
      end
   end

   // Frame counter, run flag, single pending request and the active order.
   always_ff @(posedge clk) begin
      if (rst || soft_clr) begin
         frame_cnt <= '0;
         run       <= 1'b0;
         pending   <= 1'b0;
         act_ord   <= IDENT;
      end else begin
         if (vbl_edge)    frame_cnt <= frame_wrap ? 8'd0 : frame_cnt + 8'd1;
         if (btn_fall[1]) run <= ~run;
         if (perm_busy) begin
            if (adv_req) pending <= 1'b1;
         end else begin
            pending <= 1'b0;
         end
         if (perm_done) act_ord <= work_ord;
      end
   end

   jts18_pri_perm #(
      .LAYERS (LAYERS),
      .LW     (LW)
   ) u_perm (
      .clk      (clk),
      .rst      (rst),
      .clr      (soft_clr),
      .req      (perm_req),
      .busy     (perm_busy),
      .done     (perm_done),
      .ord      (work_ord),
      .perm_cnt (perm_cnt),
      .state    (perm_state)
   );

   // Debug status selector.
   always_comb begin
      st_show = frame_cnt;
      if (debug_bus[7])      st_show = perm_cnt[7:0];
      else if (debug_bus[0]) st_show = {run, pending, perm_state, lyr_sel3};
   end

`else

   logic unused_bits;

   assign act_ord     = IDENT;
   assign st_show     = '0;
   assign unused_bits = ^{LVBL, buttons, debug_bus, 8'(VBLS)};

`endif

endmodule

// File: tb/tb_jts18_vdp_pri_seq.sv
// Self-checking bench for jts18_vdp_pri_seq (LAYERS=5, VBLS=2). The reference
// model derives the active order from the permutation index through the
// factorial number system and picks winners by plain search.
module tb_jts18_vdp_pri_seq;

   localparam int LAYERS = 5;
   localparam int LW     = $clog2(LAYERS);
   localparam int VBLS   = 2;
   localparam int NPERM  = 120;

   logic              clk = 1'b0;
   logic              rst;
   logic              LVBL;
   logic [1:0]        buttons;
   logic [7:0]        debug_bus;
   logic [LAYERS-1:0] opaque;
   logic              vdp_opaque;
   logic [2:0]        vdp_prio;
   logic              vdp_sel;
   logic [LW-1:0]     lyr_sel;
   logic              lyr_vld;
   logic [7:0]        st_show;

   int checks = 0;
   int errors = 0;
   int model_perm = 0;

   jts18_vdp_pri_seq #(
      .LAYERS (LAYERS),
      .LW     (LW),
      .VBLS   (VBLS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .LVBL       (LVBL),
      .buttons    (buttons),
      .debug_bus  (debug_bus),
      .opaque     (opaque),
      .vdp_opaque (vdp_opaque),
      .vdp_prio   (vdp_prio),
      .vdp_sel    (vdp_sel),
      .lyr_sel    (lyr_sel),
      .lyr_vld    (lyr_vld),
      .st_show    (st_show)
   );

   always #5 clk = ~clk;

   // n-th permutation of 0..LAYERS-1 in lexicographic order; o[p] = rank of plane p.
   function automatic void perm_of(input int n, output int o[LAYERS]);
      int pool[$];
      int rem, f, idx;
      rem = n;
      for (int k = 0; k < LAYERS; k++) pool.push_back(k);
      for (int pos = 0; pos < LAYERS; pos++) begin
         f = 1;
         for (int m = 2; m <= LAYERS - 1 - pos; m++) f = f * m;
         idx = rem / f;
         rem = rem % f;
         o[pos] = pool[idx];
         pool.delete(idx);
      end
   endfunction

   task automatic show(input logic [7:0] sel);
      debug_bus = sel;
      #1;
   endtask

   task automatic pulse(input logic [1:0] b);
      buttons = b;
      @(posedge clk); #1;
      buttons = 2'b11;
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      show(8'h01);
      while (k < 200 && (st_show[5:3] != 3'd0 || st_show[6])) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL %s idle_wait: state=%0d pending=%0b, expected state=0 pending=0",
                  tag, st_show[5:3], st_show[6]);
      end
   endtask

   // Random pixels against the model for the order of permutation model_perm.
   task automatic test_pixels(input string tag, input int n);
      int r[LAYERS];
      int best, win;
      logic e_vld, e_vdp;
      int   q_sel[$];
      logic q_vld[$];
      logic q_vdp[$];
      int   c_sel;
      logic c_vld, c_vdp;
      perm_of(model_perm, r);
      for (int it = 0; it <= n; it++) begin
         if (it < n) begin
            opaque     = LAYERS'($urandom);
            if ($urandom_range(0, 3) == 0) opaque = '0;
            vdp_opaque = 1'($urandom);
            vdp_prio   = 3'($urandom);
            best = -1;
            win  = 0;
            for (int p = 0; p < LAYERS; p++)
               if (opaque[p] && r[p] > best) begin
                  best = r[p];
                  win  = p;
               end
            e_vld = (opaque != '0);
            e_vdp = vdp_opaque && (!e_vld || int'(vdp_prio) > best);
            q_sel.push_back(win);
            q_vld.push_back(e_vld);
            q_vdp.push_back(e_vdp);
         end
         @(posedge clk); #1;
         if (it >= 1) begin
            c_sel = q_sel.pop_front();
            c_vld = q_vld.pop_front();
            c_vdp = q_vdp.pop_front();
            checks++;
            if (lyr_vld !== c_vld || vdp_sel !== c_vdp ||
                (c_vld && int'(lyr_sel) != c_sel)) begin
               errors++;
               $display("FAIL %s pixel%0d perm%0d: sel=%0d vld=%0b vdp=%0b, expected sel=%0d vld=%0b vdp=%0b",
                        tag, it - 1, model_perm, lyr_sel, lyr_vld, vdp_sel, c_sel, c_vld, c_vdp);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (vdp_sel !== 1'b0 || lyr_sel !== '0 || lyr_vld !== 1'b0 || st_show !== 8'd0) begin
         errors++;
         $display("FAIL reset: vdp_sel=%0b lyr_sel=%0d lyr_vld=%0b st_show=%0d, expected all 0",
                  vdp_sel, lyr_sel, lyr_vld, st_show);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_plan_pixels();
      opaque = 5'b00110; vdp_opaque = 1'b1; vdp_prio = 3'd2;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (lyr_sel !== 3'd2 || vdp_sel !== 1'b0 || lyr_vld !== 1'b1) begin
         errors++;
         $display("FAIL tie_plane_wins: sel=%0d vdp=%0b vld=%0b, expected sel=2 vdp=0 vld=1",
                  lyr_sel, vdp_sel, lyr_vld);
      end
      vdp_prio = 3'd3;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (vdp_sel !== 1'b1) begin
         errors++;
         $display("FAIL vdp_higher_wins: vdp=%0b, expected 1", vdp_sel);
      end
   endtask

`ifdef JTS18_PRI_SEQ_EN

   task automatic test_step();
      pulse(2'b10);
      wait_idle("step");
      model_perm = (model_perm + 1) % NPERM;
      show(8'h80);
      checks++;
      if (st_show !== 8'(model_perm)) begin
         errors++;
         $display("FAIL step_perm_cnt: got %0d, expected %0d", st_show, model_perm);
      end
      opaque = 5'b11000; vdp_opaque = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (lyr_sel !== 3'd3 || lyr_vld !== 1'b1) begin
         errors++;
         $display("FAIL step_order: sel=%0d vld=%0b, expected sel=3 vld=1", lyr_sel, lyr_vld);
      end
      test_pixels("step", 40);
   endtask

   task automatic test_run_wrap();
      buttons = 2'b00;
      @(posedge clk); #1;
      buttons = 2'b11;
      model_perm = 0;
      show(8'h80);
      checks++;
      if (st_show !== 8'd0) begin
         errors++;
         $display("FAIL clear_perm_cnt: got %0d, expected 0", st_show);
      end
      pulse(2'b01);
      show(8'h01);
      checks++;
      if (st_show[7] !== 1'b1) begin
         errors++;
         $display("FAIL run_on: run=%0b, expected 1", st_show[7]);
      end
      for (int e = 1; e <= 240; e++) begin
         LVBL = 1'b0;
         repeat (10) @(posedge clk);
         #1;
         LVBL = 1'b1;
         repeat (10) @(posedge clk);
         #1;
         if (e == 120 || e == 238 || e == 240) begin
            wait_idle("run");
            model_perm = (e / VBLS) % NPERM;
            show(8'h80);
            checks++;
            if (st_show !== 8'(model_perm)) begin
               errors++;
               $display("FAIL run_perm_cnt edge%0d: got %0d, expected %0d", e, st_show, model_perm);
            end
            show(8'h00);
            checks++;
            if (st_show !== 8'(e % VBLS)) begin
               errors++;
               $display("FAIL frame_cnt edge%0d: got %0d, expected %0d", e, st_show, e % VBLS);
            end
            test_pixels("run", 20);
         end
      end
      pulse(2'b01);
      show(8'h01);
      checks++;
      if (st_show[7] !== 1'b0) begin
         errors++;
         $display("FAIL run_off: run=%0b, expected 0", st_show[7]);
      end
   endtask

   task automatic test_back_to_back();
      wait_idle("b2b_start");
      show(8'h01);
      buttons = 2'b10;
      @(posedge clk); #1;
      buttons = 2'b11;
      @(posedge clk); #1;
      buttons = 2'b10;
      @(posedge clk); #1;
      checks++;
      if (st_show[6] !== 1'b1) begin
         errors++;
         $display("FAIL pending_set: pending=%0b, expected 1", st_show[6]);
      end
      buttons = 2'b11;
      @(posedge clk); #1;
      buttons = 2'b10;
      @(posedge clk); #1;
      buttons = 2'b11;
      wait_idle("b2b");
      model_perm = (model_perm + 2) % NPERM;
      show(8'h80);
      checks++;
      if (st_show !== 8'(model_perm)) begin
         errors++;
         $display("FAIL b2b_perm_cnt: got %0d, expected %0d", st_show, model_perm);
      end
      test_pixels("b2b", 30);
   endtask

   task automatic test_clear_mid_reverse();
      int k;
      pulse(2'b01);
      show(8'h01);
      buttons = 2'b10;
      @(posedge clk); #1;
      buttons = 2'b11;
      k = 0;
      while (k < 50 && st_show[5:3] != 3'd4) begin
         @(posedge clk); #1;
         k++;
      end
      checks++;
      if (k >= 50) begin
         errors++;
         $display("FAIL reverse_wait: state=%0d, expected 4", st_show[5:3]);
      end
      buttons = 2'b00;
      @(posedge clk); #1;
      checks++;
      if (st_show[7:3] !== 5'd0) begin
         errors++;
         $display("FAIL clear_fsm: run=%0b pending=%0b state=%0d, expected 0 0 0",
                  st_show[7], st_show[6], st_show[5:3]);
      end
      buttons = 2'b11;
      model_perm = 0;
      show(8'h80);
      checks++;
      if (st_show !== 8'd0) begin
         errors++;
         $display("FAIL clear_mid_perm_cnt: got %0d, expected 0", st_show);
      end
      test_pixels("cleared", 30);
   endtask

`else

   task automatic test_disabled();
      pulse(2'b10);
      pulse(2'b01);
      pulse(2'b00);
      for (int k = 0; k < 6; k++) begin
         LVBL = ~LVBL;
         repeat (3) @(posedge clk);
         #1;
      end
      for (int k = 0; k < 4; k++) begin
         show(8'($urandom) | 8'h81);
         checks++;
         if (st_show !== 8'd0) begin
            errors++;
            $display("FAIL disabled_st_show: got %0d, expected 0", st_show);
         end
      end
      model_perm = 0;
      test_pixels("disabled", 40);
   endtask

`endif

   initial begin
      rst = 1'b1; LVBL = 1'b1; buttons = 2'b11; debug_bus = 8'h00;
      opaque = '0; vdp_opaque = 1'b0; vdp_prio = 3'd0;
      @(posedge clk); #1;
      test_reset();
      test_plan_pixels();
      test_pixels("identity", 60);
`ifdef JTS18_PRI_SEQ_EN
      test_step();
      test_run_wrap();
      test_back_to_back();
      test_clear_mid_reverse();
`else
      test_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
